// File: rtl/cpu_bus_sequencer.sv
`default_nettype none
// ============================================================================
// cpu_bus_sequencer: M-cycle bus sequencer with wait stretch and imm lanes.
// Revision: 1.0
// ============================================================================
module cpu_bus_sequencer #(
  parameter int AW        = 16,
  parameter int DW        = 8,
  parameter int T_PER_M   = 4,
  parameter int IMM_BYTES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [1:0]                   req_op,
  input  logic [AW-1:0]                req_addr,
  input  logic [DW-1:0]                req_wdata,
  input  logic [$clog2(IMM_BYTES):0]   req_lane,
  input  logic                         req_imm_clr,
  input  logic                         bus_wait,
  input  logic [DW-1:0]                din,
  output logic [AW-1:0]                a,
  output logic [DW-1:0]                dout,
  output logic                         rd,
  output logic                         wr,
  output logic                         phi,
  output logic [$clog2(T_PER_M)-1:0]   t_state,
  output logic [DW-1:0]                opcode,
  output logic [DW-1:0]                rdata,
  output logic [IMM_BYTES*DW-1:0]      imm,
  output logic                         m_done,
  output logic [15:0]                  mcycle_cnt
);

  localparam int TW = $clog2(T_PER_M);
  localparam int LW = $clog2(IMM_BYTES) + 1;
  localparam logic [TW-1:0] c_t_last = TW'(T_PER_M - 1);
  localparam logic [TW-1:0] c_t_hold = TW'(T_PER_M - 2);
  localparam logic [LW-1:0] c_lanes  = LW'(IMM_BYTES);

  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_FETCH = 2'b01,
    OP_WRITE = 2'b10,
    OP_READ  = 2'b11
  } op_e;

  logic [TW-1:0]           t_q, t_d;
  op_e                     op_q, op_d;
  logic [DW-1:0]           wdata_q, wdata_d;
  logic [LW-1:0]           lane_q, lane_d;
  logic [AW-1:0]           a_q, a_d;
  logic [DW-1:0]           dout_q, dout_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;
  logic                    phi_q, phi_d;
  logic [DW-1:0]           opcode_q, opcode_d;
  logic [DW-1:0]           rdata_q, rdata_d;
  logic [IMM_BYTES*DW-1:0] imm_q, imm_d;
  logic                    m_done_q, m_done_d;
  logic [15:0]             cnt_q, cnt_d;

  always_comb begin
    t_d      = t_q;
    op_d     = op_q;
    wdata_d  = wdata_q;
    lane_d   = lane_q;
    a_d      = a_q;
    dout_d   = dout_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    phi_d    = phi_q;
    opcode_d = opcode_q;
    rdata_d  = rdata_q;
    imm_d    = imm_q;
    m_done_d = 1'b0;
    cnt_d    = cnt_q;

    // Wait only stretches the state before the last, and only for real ops.
    if (t_q == c_t_last) begin
      t_d = '0;
    end else if (!(t_q == c_t_hold && bus_wait && op_q != OP_IDLE)) begin
      t_d = t_q + TW'(1);
    end

    if (t_q == '0) begin
      op_d    = req_valid ? op_e'(req_op) : OP_IDLE;
      wdata_d = req_wdata;
      lane_d  = req_lane;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      dout_d  = '0;
      if (req_valid && req_op != OP_IDLE) begin
        a_d = req_addr;
      end
      if (req_valid && req_imm_clr) begin
        imm_d = '0;
      end
    end else if (t_q == TW'(1)) begin
      rd_d  = (op_q == OP_FETCH) || (op_q == OP_READ);
      wr_d  = 1'b0;
      phi_d = 1'b1;
    end else if (t_q == c_t_last) begin
      rd_d  = 1'b0;
      phi_d = 1'b0;
      case (op_q)
        OP_WRITE: begin
          wr_d   = 1'b1;
          dout_d = wdata_q;
        end
        OP_FETCH: opcode_d = din;
        OP_READ: begin
          rdata_d = din;
          if (lane_q < c_lanes) begin
            imm_d[int'(lane_q)*DW +: DW] = din;
          end
        end
        default: ;
      endcase
      if (op_q != OP_IDLE) begin
        m_done_d = 1'b1;
        cnt_d    = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_q      <= '0;
      op_q     <= OP_IDLE;
      wdata_q  <= '0;
      lane_q   <= '0;
      a_q      <= '0;
      dout_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      phi_q    <= 1'b0;
      opcode_q <= '0;
      rdata_q  <= '0;
      imm_q    <= '0;
      m_done_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      t_q      <= t_d;
      op_q     <= op_d;
      wdata_q  <= wdata_d;
      lane_q   <= lane_d;
      a_q      <= a_d;
      dout_q   <= dout_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      phi_q    <= phi_d;
      opcode_q <= opcode_d;
      rdata_q  <= rdata_d;
      imm_q    <= imm_d;
      m_done_q <= m_done_d;
      cnt_q    <= cnt_d;
    end
  end

  assign req_ready  = (t_q == '0);
  assign t_state    = t_q;
  assign a          = a_q;
  assign dout       = dout_q;
  assign rd         = rd_q;
  assign wr         = wr_q;
  assign phi        = phi_q;
  assign opcode     = opcode_q;
  assign rdata      = rdata_q;
  assign imm        = imm_q;
  assign m_done     = m_done_q;
  assign mcycle_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_sequencer.sv
`default_nettype none
// ============================================================================
// tb_cpu_bus_sequencer: directed checks of the bus sequencer, T_PER_M 4 and 6.
// Revision: 1.0
// ============================================================================
module tb_cpu_bus_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4, rst6, req_valid, req_imm_clr, bus_wait;
  logic [1:0]  req_op, req_lane;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata, din;

  logic        ready4, rd4, wr4, phi4, mdone4;
  logic [15:0] a4, cnt4, imm4;
  logic [7:0]  dout4, opc4, rdat4;
  logic [1:0]  t4;

  logic        ready6, rd6, wr6, phi6, mdone6;
  logic [15:0] a6, cnt6, imm6;
  logic [7:0]  dout6, opc6, rdat6;
  logic [2:0]  t6;

  cpu_bus_sequencer #(.AW(16), .DW(8), .T_PER_M(4), .IMM_BYTES(2)) u_dut4 (
    .clk(clk), .rst(rst4), .req_valid(req_valid), .req_ready(ready4),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_lane(req_lane), .req_imm_clr(req_imm_clr), .bus_wait(bus_wait),
    .din(din), .a(a4), .dout(dout4), .rd(rd4), .wr(wr4), .phi(phi4),
    .t_state(t4), .opcode(opc4), .rdata(rdat4), .imm(imm4),
    .m_done(mdone4), .mcycle_cnt(cnt4)
  );

  cpu_bus_sequencer #(.AW(16), .DW(8), .T_PER_M(6), .IMM_BYTES(2)) u_dut6 (
    .clk(clk), .rst(rst6), .req_valid(req_valid), .req_ready(ready6),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_lane(req_lane), .req_imm_clr(req_imm_clr), .bus_wait(bus_wait),
    .din(din), .a(a6), .dout(dout6), .rd(rd6), .wr(wr6), .phi(phi6),
    .t_state(t6), .opcode(opc6), .rdata(rdat6), .imm(imm6),
    .m_done(mdone6), .mcycle_cnt(cnt6)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick();
  endtask

  // Presents a request during T0 and returns one clock later, in T1.
  task automatic issue(input logic [1:0] op, input logic [15:0] addr,
                       input logic [7:0] wd, input logic [1:0] lane, input logic clr);
    req_valid   = 1'b1;
    req_op      = op;
    req_addr    = addr;
    req_wdata   = wd;
    req_lane    = lane;
    req_imm_clr = clr;
    tick();
    req_valid   = 1'b0;
    req_op      = 2'b00;
    req_imm_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst4 = 1'b1; rst6 = 1'b1;
    req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_wdata = '0;
    req_lane = '0; req_imm_clr = 1'b0; bus_wait = 1'b0; din = '0;
    tick_n(3);
    rst4 = 1'b0;

    check("rst_t",      t4,     0);
    check("rst_ready",  ready4, 1);
    check("rst_a",      a4,     0);
    check("rst_dout",   dout4,  0);
    check("rst_strobe", {rd4, wr4, phi4}, 0);
    check("rst_opcode", opc4,   0);
    check("rst_rdata",  rdat4,  0);
    check("rst_imm",    imm4,   0);
    check("rst_mdone",  mdone4, 0);
    check("rst_cnt",    cnt4,   0);

    // Fetch
    issue(2'b01, 16'h0150, 8'h00, 2'd0, 1'b0);
    check("f_t1",     t4,     1);
    check("f_a_t1",   a4,     16'h0150);
    check("f_ready0", ready4, 0);
    check("f_rd_t1",  rd4,    0);
    din = 8'h3E;
    tick();
    check("f_rd_t2",  rd4,    1);
    check("f_phi_t2", phi4,   1);
    tick();
    check("f_rd_t3",  rd4,    1);
    tick();
    check("f_rd_t0",  rd4,    0);
    check("f_phi_t0", phi4,   0);
    check("f_opcode", opc4,   8'h3E);
    check("f_mdone",  mdone4, 1);
    check("f_cnt",    cnt4,   1);

    // Write, issued back-to-back
    issue(2'b10, 16'hFF80, 8'hA5, 2'd0, 1'b0);
    check("w_mdone_t1", mdone4, 0);
    check("w_a",        a4,     16'hFF80);
    tick();
    check("w_strobe_t2", {rd4, wr4}, 0);
    tick_n(2);
    check("w_wr_t0",   wr4,    1);
    check("w_dout_t0", dout4,  8'hA5);
    check("w_mdone",   mdone4, 1);
    check("w_cnt",     cnt4,   2);
    tick();
    check("w_wr_t1",   wr4,    0);
    check("w_dout_t1", dout4,  0);

    // Idle M-cycle
    seen = 1'b0;
    repeat (3) begin
      tick();
      seen = seen | rd4 | wr4 | mdone4;
    end
    check("idle_t0",    t4,   0);
    check("idle_quiet", seen, 0);
    check("idle_cnt",   cnt4, 2);
    check("idle_a",     a4,   16'hFF80);

    // Immediate assembly by lane
    issue(2'b11, 16'h0010, 8'h00, 2'd1, 1'b1);
    din = 8'h12;
    tick_n(3);
    check("r1_rdata", rdat4, 8'h12);
    check("r1_imm",   imm4,  16'h1200);
    check("r1_cnt",   cnt4,  3);
    issue(2'b11, 16'h0011, 8'h00, 2'd0, 1'b0);
    din = 8'h34;
    tick_n(3);
    check("r2_imm",   imm4,  16'h1234);
    check("r2_rdata", rdat4, 8'h34);
    issue(2'b11, 16'h0012, 8'h00, 2'd2, 1'b0);
    din = 8'h77;
    tick_n(3);
    check("r3_imm_keep", imm4,  16'h1234);
    check("r3_rdata",    rdat4, 8'h77);
    check("r3_cnt",      cnt4,  5);
    issue(2'b11, 16'h0013, 8'h00, 2'd0, 1'b1);
    din = 8'h56;
    tick_n(3);
    check("r4_imm_clr", imm4, 16'h0056);
    check("r4_cnt",     cnt4, 6);

    // Read stretched by three wait clocks in T2
    issue(2'b11, 16'h2000, 8'h00, 2'd3, 1'b0);
    bus_wait = 1'b1;
    din = 8'h11;
    tick();
    check("wt_rd_t2", rd4, 1);
    tick_n(2);
    check("wt_hold_t", t4, 2);
    tick();
    check("wt_hold_t3", t4,     2);
    check("wt_rd_hold", rd4,    1);
    check("wt_mdone0",  mdone4, 0);
    bus_wait = 1'b0;
    tick();
    check("wt_t3", t4, 3);
    din = 8'h9C;
    tick();
    check("wt_t0",    t4,     0);
    check("wt_mdone", mdone4, 1);
    check("wt_rdata", rdat4,  8'h9C);
    check("wt_imm",   imm4,   16'h0056);
    check("wt_cnt",   cnt4,   7);

    // Reset in T3 of a write
    issue(2'b10, 16'h1234, 8'h5A, 2'd0, 1'b0);
    tick_n(2);
    check("rm_t3", t4, 3);
    rst4 = 1'b1;
    tick();
    check("rm_wr",    wr4,    0);
    check("rm_dout",  dout4,  0);
    check("rm_t",     t4,     0);
    check("rm_mdone", mdone4, 0);
    check("rm_cnt",   cnt4,   0);
    check("rm_rd",    rd4,    0);

    // T_PER_M = 6 instance: fetch, idle, read
    rst6 = 1'b0;
    check("s6_t0", t6, 0);
    issue(2'b01, 16'h0300, 8'h00, 2'd0, 1'b0);
    din = 8'hE1;
    tick_n(4);
    check("s6_f_t5",    t6,     5);
    check("s6_f_rd",    rd6,    1);
    check("s6_f_mdone", mdone6, 0);
    tick();
    check("s6_f_t0",   t6,     0);
    check("s6_opcode", opc6,   8'hE1);
    check("s6_mdone",  mdone6, 1);
    check("s6_cnt1",   cnt6,   1);
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen = seen | rd6 | wr6 | mdone6;
    end
    check("s6_idle_t0",    t6,   0);
    check("s6_idle_quiet", seen, 0);
    check("s6_idle_cnt",   cnt6, 1);
    issue(2'b11, 16'h0301, 8'h00, 2'd0, 1'b0);
    din = 8'hC3;
    tick_n(4);
    check("s6_r_rd", rd6, 1);
    tick();
    check("s6_r_rdata", rdat6,  8'hC3);
    check("s6_r_imm",   imm6,   16'h00C3);
    check("s6_r_mdone", mdone6, 1);
    check("s6_r_cnt",   cnt6,   2);
    check("s6_r_a",     a6,     16'h0301);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
